// File: rtl/reg_arb_pkg.sv
// Purpose: shared types and default constants for the register write arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a; also holds the index-to-one-hot helper used for gnt.
package reg_arb_pkg;

   // FSM encoding for the arbiter
   typedef enum logic {
      UNLOCKED = 1'b0,
      LOCKED   = 1'b1
   } state_e;

   localparam int DEF_WIDTH    = 8;
   localparam int DEF_NREQ     = 4;
   localparam int DEF_LOCK_MAX = 8;

   // Requester index width; the requester count is fixed at 4 in this revision
   localparam int IDX_W = 2;

   function automatic logic [DEF_NREQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
      idx_onehot = DEF_NREQ'(1) << idx;
   endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Purpose: request/acknowledge bundle between requesters and the arbiter.
// Latency: n/a (wiring only).
// Backpressure: none; gnt is the only acknowledge, one cycle after req.
// Signals: req/lock/wdata driven by the requester side (master);
//          q/gnt/owner/locked driven by the arbiter (slave).
interface reg_write_arbiter_if
   import reg_arb_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int NREQ  = DEF_NREQ
);
   logic [NREQ-1:0]       req;
   logic [NREQ-1:0]       lock;
   logic [NREQ*WIDTH-1:0] wdata;
   logic [WIDTH-1:0]      q;
   logic [NREQ-1:0]       gnt;
   logic [IDX_W-1:0]      owner;
   logic                  locked;

   modport master (
      output req, lock, wdata,
      input  q, gnt, owner, locked
   );

   modport slave (
      input  req, lock, wdata,
      output q, gnt, owner, locked
   );
endinterface

// File: rtl/reg_write_arbiter_rr_pick.sv
// Purpose: combinational round-robin picker, first set req at or above ptr (mod 4).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; valid is low when no request is set.
// Ports: req (requests), ptr (search start) -> valid, index (winner).
module rr_pick
   import reg_arb_pkg::*;
(
   input  logic [DEF_NREQ-1:0] req,
   input  logic [IDX_W-1:0]    ptr,
   output logic                valid,
   output logic [IDX_W-1:0]    index
);

   logic [IDX_W-1:0] cand;

   always_comb begin
      valid = 1'b0;
      index = ptr;
      cand  = ptr;
      for (int i = 0; i < DEF_NREQ; i++) begin
         // 2-bit addition wraps naturally, giving the modulo-4 search order
         cand = ptr + IDX_W'(i);
         if (!valid && req[cand]) begin
            valid = 1'b1;
            index = cand;
         end
      end
   end

endmodule

// File: rtl/reg_write_arbiter.sv
// Purpose: shared register with round-robin write arbitration and optional bounded lock.
// Latency: 1 cycle, req/wdata sampled in cycle N, q and gnt visible in cycle N+1.
// Backpressure: losers get no gnt and simply keep req high; no stall of winners.
// Ports: clk, reset (sync, active-high); bus (slave) carries req, lock, wdata in and
//        q, gnt, owner, locked out.
module reg_write_arbiter
   import reg_arb_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int NREQ     = DEF_NREQ,
   parameter int LOCK_MAX = DEF_LOCK_MAX
)(
   input  logic                 clk,
   input  logic                 reset,
   reg_write_arbiter_if.slave   bus
);

   localparam int CNT_W = $clog2(LOCK_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);
   // With LOCK_MAX of 1 the entry grant already exhausts the budget, so never lock
   localparam bit CAN_LOCK = (LOCK_MAX > 1);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W-1:0] owner_q, owner_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [NREQ-1:0]  gnt_q, gnt_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic             q_en;
   logic [IDX_W-1:0] wsel;

   logic             pick_vld;
   logic [IDX_W-1:0] pick_idx;

   rr_pick u_rr_pick (
      .req   (bus.req),
      .ptr   (ptr_q),
      .valid (pick_vld),
      .index (pick_idx)
   );

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      gnt_d   = '0;
      q_en    = 1'b0;
      wsel    = owner_q;

      case (state_q)
         UNLOCKED: begin
            if (pick_vld) begin
               q_en    = 1'b1;
               wsel    = pick_idx;
               gnt_d   = idx_onehot(pick_idx);
               ptr_d   = pick_idx + 2'd1;
               owner_d = pick_idx;
               // lock only counts when it accompanies the winning req
               if (CAN_LOCK && bus.lock[pick_idx]) begin
                  state_d = LOCKED;
                  cnt_d   = CNT_ONE;
               end
            end
         end
         LOCKED: begin
            // cnt counts locked cycles whether or not the owner writes
            cnt_d = cnt_q + CNT_ONE;
            if (bus.req[owner_q]) begin
               q_en  = 1'b1;
               wsel  = owner_q;
               gnt_d = idx_onehot(owner_q);
            end
            // The write of the exiting cycle still commits; only the state changes
            if (cnt_d >= CNT_MAX) begin
               state_d = UNLOCKED;
               cnt_d   = '0;
               ptr_d   = owner_q + 2'd1;
            end else if (!bus.lock[owner_q]) begin
               state_d = UNLOCKED;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = UNLOCKED;
            cnt_d   = '0;
         end
      endcase

      q_d = bus.wdata[int'(wsel)*WIDTH +: WIDTH];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= UNLOCKED;
         ptr_q   <= '0;
         owner_q <= '0;
         cnt_q   <= '0;
         gnt_q   <= '0;
         q_q     <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         if (q_en) begin
            q_q <= q_d;
         end
      end
   end

   assign bus.q      = q_q;
   assign bus.gnt    = gnt_q;
   assign bus.owner  = owner_q;
   assign bus.locked = (state_q == LOCKED);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Purpose: directed self-checking bench for reg_write_arbiter.
// Latency: inputs driven 1ns after a rising edge, results read 1ns after the next edge.
// Backpressure: n/a.
module tb_reg_write_arbiter;

   logic clk;
   logic reset;
   int   tests;
   int   fails;

   reg_write_arbiter_if #(.WIDTH(8), .NREQ(4)) bus ();

   reg_write_arbiter #(.WIDTH(8), .NREQ(4), .LOCK_MAX(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; outputs then reflect the inputs held during that cycle
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] r, input logic [3:0] l);
      bus.req  = r;
      bus.lock = l;
   endtask

   task automatic set_wdata(input logic [7:0] d3, input logic [7:0] d2,
                            input logic [7:0] d1, input logic [7:0] d0);
      bus.wdata = {d3, d2, d1, d0};
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(4'b0000, 4'b0000);
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(4'b1111, 4'b1111);
      set_wdata(8'hFF, 8'hFF, 8'hFF, 8'hFF);
      step();
      tests++; if (bus.q !== 8'h00) begin fails++; $display("FAIL reset_q: got %h want 00", bus.q); end
      tests++; if (bus.gnt !== 4'b0000) begin fails++; $display("FAIL reset_gnt: got %b want 0000", bus.gnt); end
      tests++; if (bus.owner !== 2'd0) begin fails++; $display("FAIL reset_owner: got %0d want 0", bus.owner); end
      tests++; if (bus.locked !== 1'b0) begin fails++; $display("FAIL reset_locked: got %b want 0", bus.locked); end
      reset = 1'b0;
      drive(4'b0000, 4'b0000);
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_gnt [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
      logic [7:0] exp_q   [4] = '{8'h10, 8'h11, 8'h12, 8'h13};
      do_reset();
      set_wdata(8'h13, 8'h12, 8'h11, 8'h10);
      drive(4'b1111, 4'b0000);
      for (int k = 0; k < 4; k++) begin
         step();
         tests++; if (bus.gnt !== exp_gnt[k]) begin fails++; $display("FAIL rr_gnt[%0d]: got %b want %b", k, bus.gnt, exp_gnt[k]); end
         tests++; if (bus.q !== exp_q[k]) begin fails++; $display("FAIL rr_q[%0d]: got %h want %h", k, bus.q, exp_q[k]); end
         tests++; if (bus.owner !== 2'(k)) begin fails++; $display("FAIL rr_owner[%0d]: got %0d want %0d", k, bus.owner, k); end
      end
   endtask

   task automatic test_ptr_wrap_and_idle();
      do_reset();
      set_wdata(8'h23, 8'h22, 8'h21, 8'h20);
      // grant to 1 leaves ptr at 2
      drive(4'b0010, 4'b0000);
      step();
      tests++; if (bus.gnt !== 4'b0010) begin fails++; $display("FAIL wrap_setup_gnt: got %b want 0010", bus.gnt); end
      drive(4'b0011, 4'b0000);
      step();
      tests++; if (bus.gnt !== 4'b0001) begin fails++; $display("FAIL wrap_gnt0: got %b want 0001", bus.gnt); end
      tests++; if (bus.q !== 8'h20) begin fails++; $display("FAIL wrap_q0: got %h want 20", bus.q); end
      step();
      tests++; if (bus.gnt !== 4'b0010) begin fails++; $display("FAIL wrap_gnt1: got %b want 0010", bus.gnt); end
      tests++; if (bus.q !== 8'h21) begin fails++; $display("FAIL wrap_q1: got %h want 21", bus.q); end
      // idle: nothing changes but gnt drops
      drive(4'b0000, 4'b1111);
      set_wdata(8'hEE, 8'hEE, 8'hEE, 8'hEE);
      for (int k = 0; k < 3; k++) begin
         step();
         tests++; if (bus.gnt !== 4'b0000) begin fails++; $display("FAIL idle_gnt[%0d]: got %b want 0000", k, bus.gnt); end
         tests++; if (bus.q !== 8'h21) begin fails++; $display("FAIL idle_q[%0d]: got %h want 21", k, bus.q); end
         tests++; if (bus.owner !== 2'd1) begin fails++; $display("FAIL idle_owner[%0d]: got %0d want 1", k, bus.owner); end
         tests++; if (bus.locked !== 1'b0) begin fails++; $display("FAIL idle_locked[%0d]: got %b want 0", k, bus.locked); end
      end
   endtask

   task automatic test_lock_max();
      logic [3:0] exp_gnt [12] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010,
                                   4'b0010, 4'b0010, 4'b1000, 4'b0010, 4'b0010, 4'b0010};
      logic       exp_lk  [12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                   1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      int         run1;
      do_reset();
      set_wdata(8'h33, 8'h32, 8'h31, 8'h30);
      drive(4'b1010, 4'b0010);
      run1 = 0;
      for (int k = 0; k < 12; k++) begin
         step();
         if (k < 9 && bus.gnt == 4'b0010) run1++;
         tests++; if (bus.gnt !== exp_gnt[k]) begin fails++; $display("FAIL lockmax_gnt[%0d]: got %b want %b", k, bus.gnt, exp_gnt[k]); end
         tests++; if (bus.locked !== exp_lk[k]) begin fails++; $display("FAIL lockmax_locked[%0d]: got %b want %b", k, bus.locked, exp_lk[k]); end
      end
      tests++; if (run1 != 8) begin fails++; $display("FAIL lockmax_run: got %0d grants want 8", run1); end
      tests++; if (bus.q !== 8'h31) begin fails++; $display("FAIL lockmax_q: got %h want 31", bus.q); end
   endtask

   task automatic test_lock_release();
      do_reset();
      set_wdata(8'h03, 8'h40, 8'h01, 8'h00);
      drive(4'b0100, 4'b0100);
      step();
      tests++; if (bus.gnt !== 4'b0100) begin fails++; $display("FAIL rel_enter_gnt: got %b want 0100", bus.gnt); end
      tests++; if (bus.locked !== 1'b1) begin fails++; $display("FAIL rel_enter_locked: got %b want 1", bus.locked); end
      // other requester is ignored while locked
      set_wdata(8'h03, 8'h41, 8'h01, 8'h00);
      drive(4'b0101, 4'b0100);
      step();
      tests++; if (bus.gnt !== 4'b0100) begin fails++; $display("FAIL rel_hold_gnt: got %b want 0100", bus.gnt); end
      tests++; if (bus.q !== 8'h41) begin fails++; $display("FAIL rel_hold_q: got %h want 41", bus.q); end
      // owner pauses its request: no write, lock still held
      drive(4'b0001, 4'b0100);
      step();
      tests++; if (bus.gnt !== 4'b0000) begin fails++; $display("FAIL rel_pause_gnt: got %b want 0000", bus.gnt); end
      tests++; if (bus.q !== 8'h41) begin fails++; $display("FAIL rel_pause_q: got %h want 41", bus.q); end
      tests++; if (bus.locked !== 1'b1) begin fails++; $display("FAIL rel_pause_locked: got %b want 1", bus.locked); end
      // lock drops with a final write
      set_wdata(8'h03, 8'hA5, 8'h01, 8'h00);
      drive(4'b0100, 4'b0000);
      step();
      tests++; if (bus.gnt !== 4'b0100) begin fails++; $display("FAIL rel_exit_gnt: got %b want 0100", bus.gnt); end
      tests++; if (bus.q !== 8'hA5) begin fails++; $display("FAIL rel_exit_q: got %h want a5", bus.q); end
      tests++; if (bus.locked !== 1'b0) begin fails++; $display("FAIL rel_exit_locked: got %b want 0", bus.locked); end
      // immediate arbitration from ptr=3: search 3,0 -> 0
      drive(4'b0101, 4'b0000);
      step();
      tests++; if (bus.gnt !== 4'b0001) begin fails++; $display("FAIL rel_next_gnt: got %b want 0001", bus.gnt); end
      tests++; if (bus.q !== 8'h00) begin fails++; $display("FAIL rel_next_q: got %h want 00", bus.q); end
      // locks without matching req are ignored; ptr=1, winner 0 has no lock
      drive(4'b0001, 4'b1110);
      step();
      tests++; if (bus.gnt !== 4'b0001) begin fails++; $display("FAIL orphan_lock_gnt: got %b want 0001", bus.gnt); end
      tests++; if (bus.locked !== 1'b0) begin fails++; $display("FAIL orphan_lock_locked: got %b want 0", bus.locked); end
   endtask

   task automatic test_reset_mid_lock();
      do_reset();
      set_wdata(8'h53, 8'h52, 8'h51, 8'h50);
      drive(4'b0001, 4'b0001);
      step();
      tests++; if (bus.locked !== 1'b1) begin fails++; $display("FAIL rstlock_enter: got %b want 1", bus.locked); end
      reset = 1'b1;
      drive(4'b1111, 4'b1111);
      step();
      reset = 1'b0;
      tests++; if (bus.q !== 8'h00) begin fails++; $display("FAIL rstlock_q: got %h want 00", bus.q); end
      tests++; if (bus.gnt !== 4'b0000) begin fails++; $display("FAIL rstlock_gnt: got %b want 0000", bus.gnt); end
      tests++; if (bus.locked !== 1'b0) begin fails++; $display("FAIL rstlock_locked: got %b want 0", bus.locked); end
      drive(4'b1111, 4'b0000);
      step();
      tests++; if (bus.gnt !== 4'b0001) begin fails++; $display("FAIL rstlock_next_gnt: got %b want 0001", bus.gnt); end
      tests++; if (bus.q !== 8'h50) begin fails++; $display("FAIL rstlock_next_q: got %h want 50", bus.q); end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      reset = 1'b1;
      bus.req   = '0;
      bus.lock  = '0;
      bus.wdata = '0;
      @(posedge clk);
      #1;
      test_reset();
      test_round_robin();
      test_ptr_wrap_and_idle();
      test_lock_max();
      test_lock_release();
      test_reset_mid_lock();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, data width of the shared register.
REQ-002 Parameter NREQ, default 4, number of requesters; fixed at 4 in this revision.
REQ-003 Parameter LOCK_MAX, default 8, maximum consecutive locked grants before forced release.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-006 req  input  NREQ  per-requester write request.
REQ-007 lock  input  NREQ  per-requester request to hold ownership across cycles.
REQ-008 wdata  input  NREQ*WIDTH  flattened write data; requester i in bits [i*WIDTH +: WIDTH].
REQ-009 q  output  WIDTH  shared register contents.
REQ-010 gnt  output  NREQ  registered one-hot write acknowledge.
REQ-011 owner  output  2  index of the most recent writer.
REQ-012 locked  output  1  high while FSM is in LOCKED.

Function
REQ-013 The block SHALL sample req, lock and wdata in cycle N and commit the winner's wdata to q at the end of cycle N; q and gnt are visible in cycle N+1 (latency 1).
REQ-014 gnt SHALL be one-hot or zero; gnt is zero in any cycle following a cycle with no eligible request, and q holds its value then.
REQ-015 FSM states SHALL be UNLOCKED and LOCKED.
REQ-016 UNLOCKED: the winner SHALL be the first asserted req starting at pointer ptr and searching upward modulo 4; after a grant, ptr <= winner+1 mod 4.
REQ-017 UNLOCKED -> LOCKED when the winner also has lock high; owner <= winner; lock counter cnt <= 1.
REQ-018 LOCKED: only requester owner is eligible; other requests are ignored and not acknowledged.
REQ-019 LOCKED, req[owner]=1: write and gnt[owner] every cycle; cnt increments.
REQ-020 LOCKED, req[owner]=0: no write, gnt=0; cnt still increments.
REQ-021 LOCKED -> UNLOCKED when lock[owner]=0 at the edge; a write with req[owner]=1 in that same cycle still commits.
REQ-022 LOCKED -> UNLOCKED forced when cnt reaches LOCK_MAX; the write in that cycle commits; ptr <= owner+1 mod 4.
REQ-023 On either exit from LOCKED, the next arbitration SHALL be round-robin from ptr in the following cycle; no idle cycle is inserted.
REQ-024 A requester holding req after gnt SHALL re-compete normally; the block does not require req deassertion.
REQ-025 A lock input without the matching req SHALL be ignored.

Reset
REQ-026 While reset is high at a clk edge: q=0, gnt=0, owner=0, locked=0, ptr=0, cnt=0, state=UNLOCKED.
REQ-027 Reset SHALL take priority over any simultaneous request or lock, including mid-lock; no write commits in the reset cycle.
REQ-028 The first arbitration after reset deasserts SHALL start from requester 0.

Structure
REQ-029 Shared package reg_arb_pkg SHALL hold the state encoding (UNLOCKED=0, LOCKED=1) and the default constants for WIDTH, NREQ and LOCK_MAX.
REQ-030 Round-robin selection SHALL be a combinational sub-module rr_pick with inputs req and ptr and outputs valid and index.
REQ-031 q SHALL be a single WIDTH-bit register with an enable; no latches.

Verification
REQ-032 Reset, then req=4'b1111, lock=0, wdata[i]=8'h10+i held 4 cycles -> gnt sequence 0001, 0010, 0100, 1000; q = 10, 11, 12, 13.
REQ-033 From ptr=2, req=4'b0011 -> gnt=0001, q=wdata[0]; next cycle, same req -> gnt=0010.
REQ-034 req[1]=1 and lock[1]=1 held 12 cycles, req[3]=1 throughout -> gnt[1] for exactly 8 cycles, then locked=0; next grant goes to requester 3.
REQ-035 Locked by requester 2, lock[2] drops with req[2]=1 and wdata=8'hA5 -> q=A5 and gnt=0100 in that commit; locked=0 next cycle.
REQ-036 Locked by requester 0, reset pulsed for one cycle with req=4'b1111 -> q=0, gnt=0, locked=0; next grant goes to requester 0.
REQ-037 req=0 for 3 cycles after any write -> gnt=0, q unchanged, owner unchanged.
